// File: rtl/qdma_mailbox_fifo_rd_adapter_pkg.sv
// qdma_mbox_pkg: shared types and constants for the mailbox FIFO read adapter.
// Optional build macro: QDMA_MBOX_RD_PARITY_EN adds a per-byte parity field to each beat.
package qdma_mbox_pkg;

    localparam int MBOX_LEN_LSB     = 0;
    localparam int MBOX_DEF_MAX_LEN = 16;
    localparam int MBOX_DEF_DATA_W  = 256;

    typedef enum logic [0:0] {
        HDR = 1'b0,
        PAY = 1'b1
    } mbox_state_e;

    typedef struct packed {
        logic [MBOX_DEF_DATA_W-1:0]   data;
        logic                         last;
        logic                         user;
`ifdef QDMA_MBOX_RD_PARITY_EN
        logic [MBOX_DEF_DATA_W/8-1:0] parity;
`endif
    } mbox_beat_t;

`ifdef QDMA_MBOX_RD_PARITY_EN
    // Even parity per byte: each bit makes its byte plus itself hold an even number of ones.
    function automatic logic [MBOX_DEF_DATA_W/8-1:0] mbox_byte_parity(
        input logic [MBOX_DEF_DATA_W-1:0] d
    );
        logic [MBOX_DEF_DATA_W/8-1:0] p;
        p = '0;
        for (int b = 0; b < MBOX_DEF_DATA_W/8; b++) begin
            p[b] = ^d[b*8 +: 8];
        end
        return p;
    endfunction
`endif

endpackage

// File: rtl/qdma_mailbox_fifo_rd_adapter_if.sv
// FIFO show-ahead read port plus AXI4-Stream master bundle for the mailbox read adapter.
// Optional build macro: QDMA_MBOX_RD_PARITY_EN adds m_tparity.
interface qdma_mailbox_fifo_rd_adapter_if
    import qdma_mbox_pkg::*;
#(
    parameter int DATA_W = MBOX_DEF_DATA_W
);
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_rden;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              m_tuser;
`ifdef QDMA_MBOX_RD_PARITY_EN
    logic [DATA_W/8-1:0] m_tparity;

    modport master (
        input  fifo_dout, fifo_empty, m_tready,
        output fifo_rden, m_tdata, m_tvalid, m_tlast, m_tuser, m_tparity
    );
    modport slave (
        output fifo_dout, fifo_empty, m_tready,
        input  fifo_rden, m_tdata, m_tvalid, m_tlast, m_tuser, m_tparity
    );
`else
    modport master (
        input  fifo_dout, fifo_empty, m_tready,
        output fifo_rden, m_tdata, m_tvalid, m_tlast, m_tuser
    );
    modport slave (
        output fifo_dout, fifo_empty, m_tready,
        input  fifo_rden, m_tdata, m_tvalid, m_tlast, m_tuser
    );
`endif
endinterface

// File: rtl/qdma_mailbox_fifo_rd_adapter_skid2.sv
// qdma_mbox_skid2: 2-entry head/tail buffer; head drives the output, held while stalled.
// The producer pushes only when occupancy is below 2 or a pop happens in the same cycle.
module qdma_mbox_skid2
    import qdma_mbox_pkg::*;
#(
    parameter type T = mbox_beat_t
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       push_i,
    input  T           data_i,
    output logic       valid_o,
    input  logic       ready_i,
    output T           data_o,
    output logic [1:0] occ_o
);
    T           head_q, head_d;
    T           tail_q, tail_d;
    logic [1:0] occ_q, occ_d;
    logic       pop_s;

    assign pop_s   = ready_i & (occ_q != 2'd0);
    assign valid_o = (occ_q != 2'd0);
    assign data_o  = head_q;
    assign occ_o   = occ_q;

    // Next head/tail/occupancy from push, pop and clear.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clr_i) begin
            occ_d = 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push_i) begin
                        head_d = data_i;
                        occ_d  = 2'd1;
                    end else begin
                        occ_d = 2'd0;
                    end
                end
                2'd1: begin
                    case ({push_i, pop_s})
                        2'b11:   head_d = data_i;
                        2'b10: begin
                            tail_d = data_i;
                            occ_d  = 2'd2;
                        end
                        2'b01:   occ_d = 2'd0;
                        default: occ_d = 2'd1;
                    endcase
                end
                2'd2: begin
                    if (pop_s) begin
                        head_d = tail_q;
                        if (push_i) begin
                            tail_d = data_i;
                        end else begin
                            occ_d = 2'd1;
                        end
                    end else begin
                        occ_d = 2'd2;
                    end
                end
                default: occ_d = 2'd0;
            endcase
        end
    end

    // Buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/qdma_mailbox_fifo_rd_adapter.sv
// qdma_mailbox_fifo_rd_adapter: pops length-prefixed mailbox messages from a show-ahead
// FIFO and presents them as an AXI4-Stream master (tuser = header, tlast = final beat).
// Optional build macro: QDMA_MBOX_RD_PARITY_EN adds m_tparity and the sticky err_par flag.
module qdma_mailbox_fifo_rd_adapter
    import qdma_mbox_pkg::*;
#(
    parameter int DATA_W  = MBOX_DEF_DATA_W,
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = MBOX_DEF_MAX_LEN
) (
    input  logic clkin,
    input  logic reset,
    input  logic flush,
    qdma_mailbox_fifo_rd_adapter_if.master bus,
    output logic msg_done,
    output logic err_len
`ifdef QDMA_MBOX_RD_PARITY_EN
    ,
    output logic err_par
`endif
);
    mbox_state_e state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] hdr_len_s, clamp_len_s;
    logic err_len_q, err_len_d;
    logic msg_done_q, msg_done_d;
    logic [1:0] occ_s;
    logic out_valid_s, drain_s, room_s, pop_s;
    mbox_beat_t beat_in_s, beat_out_s;
`ifdef QDMA_MBOX_RD_PARITY_EN
    logic err_par_q, err_par_d;
`endif

    // A drain in this cycle frees a slot, so a full buffer still accepts under m_tready.
    assign drain_s = out_valid_s & bus.m_tready;
    assign room_s  = (occ_s != 2'd2) | drain_s;
    assign pop_s   = ~reset & ~flush & ~bus.fifo_empty & room_s;

    assign bus.fifo_rden = pop_s;
    assign bus.m_tvalid  = out_valid_s;
    assign bus.m_tdata   = beat_out_s.data;
    assign bus.m_tlast   = beat_out_s.last;
    assign bus.m_tuser   = beat_out_s.user;
    assign msg_done      = msg_done_q;
    assign err_len       = err_len_q;
`ifdef QDMA_MBOX_RD_PARITY_EN
    assign bus.m_tparity = beat_out_s.parity;
    assign err_par       = err_par_q;
`endif

    // Message parser: classifies each popped word and tags it with user/last.
    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        err_len_d      = err_len_q;
        hdr_len_s      = bus.fifo_dout[MBOX_LEN_LSB +: LEN_W];
        clamp_len_s    = hdr_len_s;
        beat_in_s      = '0;
        beat_in_s.data = bus.fifo_dout[DATA_W-1:0];
        msg_done_d     = drain_s & beat_out_s.last & ~flush;
`ifdef QDMA_MBOX_RD_PARITY_EN
        beat_in_s.parity = mbox_byte_parity(bus.fifo_dout);
        err_par_d        = err_par_q;
`endif
        if (flush) begin
            state_d   = HDR;
            rem_d     = '0;
            err_len_d = 1'b0;
`ifdef QDMA_MBOX_RD_PARITY_EN
            err_par_d = 1'b0;
`endif
        end else if (pop_s) begin
            case (state_q)
                HDR: begin
                    beat_in_s.user = 1'b1;
                    if (hdr_len_s > LEN_W'(MAX_LEN)) begin
                        err_len_d   = 1'b1;
                        clamp_len_s = LEN_W'(MAX_LEN);
                    end else begin
                        clamp_len_s = hdr_len_s;
                    end
                    if (clamp_len_s == '0) begin
                        beat_in_s.last = 1'b1;
                        state_d        = HDR;
                    end else begin
                        rem_d   = clamp_len_s;
                        state_d = PAY;
                    end
                end
                PAY: begin
                    beat_in_s.user = 1'b0;
                    rem_d          = rem_q - LEN_W'(1'b1);
`ifdef QDMA_MBOX_RD_PARITY_EN
                    // An all-ones payload word is the upstream poison marker.
                    if (&bus.fifo_dout) begin
                        err_par_d = 1'b1;
                    end else begin
                        err_par_d = err_par_q;
                    end
`endif
                    if (rem_q == LEN_W'(1'b1)) begin
                        beat_in_s.last = 1'b1;
                        state_d        = HDR;
                    end else begin
                        beat_in_s.last = 1'b0;
                        state_d        = PAY;
                    end
                end
                default: state_d = HDR;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Parser state, sticky error flags and the message-done pulse.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q    <= HDR;
            rem_q      <= '0;
            err_len_q  <= 1'b0;
            msg_done_q <= 1'b0;
`ifdef QDMA_MBOX_RD_PARITY_EN
            err_par_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            err_len_q  <= err_len_d;
            msg_done_q <= msg_done_d;
`ifdef QDMA_MBOX_RD_PARITY_EN
            err_par_q  <= err_par_d;
`endif
        end
    end

    qdma_mbox_skid2 #(
        .T (mbox_beat_t)
    ) u_skid (
        .clk_i   (clkin),
        .rst_i   (reset),
        .clr_i   (flush),
        .push_i  (pop_s),
        .data_i  (beat_in_s),
        .valid_o (out_valid_s),
        .ready_i (bus.m_tready),
        .data_o  (beat_out_s),
        .occ_o   (occ_s)
    );

endmodule

// File: tb/tb_qdma_mailbox_fifo_rd_adapter.sv
// Bench for qdma_mailbox_fifo_rd_adapter: a queue-based FIFO feeds messages, a message-level
// model lists the expected beats, and a negedge monitor compares every handshake.
module tb_qdma_mailbox_fifo_rd_adapter;
    localparam int DW = 256;
    localparam int MAXL = 16;

    typedef struct {
        logic [DW-1:0] data;
        bit            user;
        bit            last;
    } exp_t;

    logic clkin = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic msg_done, err_len;
`ifdef QDMA_MBOX_RD_PARITY_EN
    logic err_par;
`endif

    qdma_mailbox_fifo_rd_adapter_if #(.DATA_W(DW)) bus();

    qdma_mailbox_fifo_rd_adapter dut (
        .clkin    (clkin),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus),
        .msg_done (msg_done),
`ifdef QDMA_MBOX_RD_PARITY_EN
        .err_par  (err_par),
`endif
        .err_len  (err_len)
    );

    always #5 clkin = ~clkin;

    logic [DW-1:0] fq[$];
    exp_t          exp_q[$];
    exp_t          mon_e;
    int  checks = 0, errors = 0;
    int  rden_cnt = 0, done_cnt = 0, beat_cnt = 0;
    bit  rden_neg = 1'b0, exp_err = 1'b0;
    bit  done_pend = 1'b0, stall_prev = 1'b0, flush_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last, prev_user;
    logic [DW-1:0] last_hdr;

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

`ifdef QDMA_MBOX_RD_PARITY_EN
    function automatic logic [DW/8-1:0] exp_par(input logic [DW-1:0] d);
        logic [DW/8-1:0] p;
        int ones;
        for (int b = 0; b < DW/8; b++) begin
            ones = 0;
            for (int k = 0; k < 8; k++) ones += int'(d[b*8+k]);
            p[b] = (ones % 2) == 1;
        end
        return p;
    endfunction
`endif

    task automatic drive_fifo();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // One clock: after the edge, retire the word the DUT popped and refresh the FIFO port.
    task automatic tick();
        @(posedge clkin);
        #1;
        if (rden_neg && fq.size() != 0) void'(fq.pop_front());
        drive_fifo();
    endtask

    // Push a message: header carries field in [7:0]; npay payload words follow.
    task automatic push_msg(input int field, input int npay, input int tag);
        int   len;
        exp_t e;
        len = (field > MAXL) ? MAXL : field;
        if (field > MAXL) exp_err = 1'b1;
        e.data = (DW'(tag) << 8) | DW'(field);
        e.user = 1'b1;
        e.last = (len == 0);
        last_hdr = e.data;
        fq.push_back(e.data);
        exp_q.push_back(e);
        for (int i = 0; i < npay; i++) begin
            e.data = (DW'(32'hBEEF0000 | tag) << 160) | (DW'(tag) << 32) | DW'(i + 1);
            e.user = 1'b0;
            e.last = (i == len - 1);
            fq.push_back(e.data);
            exp_q.push_back(e);
        end
        drive_fifo();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || bus.m_tvalid) && n < budget) begin
            tick();
            n++;
        end
        chk1("drain_in_budget", n < budget, 1'b1);
        tick();
        tick();
    endtask

    task automatic clear_counts();
        rden_cnt = 0;
        done_cnt = 0;
        beat_cnt = 0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.m_tvalid && n < budget) begin
            tick();
            n++;
        end
        chk1("valid_in_budget", n < budget, 1'b1);
    endtask

    // Compare process: every handshake against the model, AXI hold rule, msg_done timing.
    always @(negedge clkin) begin
        rden_neg = bus.fifo_rden;
        if (reset) begin
            done_pend  = 1'b0;
            stall_prev = 1'b0;
            flush_prev = 1'b0;
        end else begin
            rden_cnt += int'(bus.fifo_rden);
            done_cnt += int'(msg_done);
            chk1("msg_done", msg_done, done_pend);
            done_pend = 1'b0;
            if (stall_prev && !flush_prev) begin
                chk1("hold_valid", bus.m_tvalid, 1'b1);
                chkw("hold_data", bus.m_tdata, prev_data);
                chk1("hold_last", bus.m_tlast, prev_last);
                chk1("hold_user", bus.m_tuser, prev_user);
            end
            if (bus.m_tvalid && bus.m_tready) begin
                chk1("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chkw("beat_data", bus.m_tdata, mon_e.data);
                    chk1("beat_user", bus.m_tuser, mon_e.user);
                    chk1("beat_last", bus.m_tlast, mon_e.last);
`ifdef QDMA_MBOX_RD_PARITY_EN
                    chkw("beat_parity", DW'(bus.m_tparity), DW'(exp_par(mon_e.data)));
`endif
                    if (mon_e.last && !flush) done_pend = 1'b1;
                    beat_cnt++;
                end
            end
            stall_prev = bus.m_tvalid && !bus.m_tready;
            prev_data  = bus.m_tdata;
            prev_last  = bus.m_tlast;
            prev_user  = bus.m_tuser;
            flush_prev = flush;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.m_tready = 1'b0;
        fq.push_back(DW'(32'h1234));
        drive_fifo();
        #12;
        // Reset state, with a non-empty FIFO presented
        chk1("rst_rden", bus.fifo_rden, 1'b0);
        chk1("rst_tvalid", bus.m_tvalid, 1'b0);
        chkw("rst_tdata", bus.m_tdata, '0);
        chk1("rst_tlast", bus.m_tlast, 1'b0);
        chk1("rst_tuser", bus.m_tuser, 1'b0);
        chk1("rst_msg_done", msg_done, 1'b0);
        chk1("rst_err_len", err_len, 1'b0);
        fq.delete();
        drive_fifo();
        @(posedge clkin);
        #1 reset = 1'b0;
        tick();

        // N=3 with continuous ready
        bus.m_tready = 1'b1;
        clear_counts();
        push_msg(3, 3, 1);
        drain(50);
        chki("t1_rden_cycles", rden_cnt, 4);
        chki("t1_beats", beat_cnt, 4);
        chki("t1_msg_done", done_cnt, 1);

        // N=0 then N=1
        clear_counts();
        push_msg(0, 0, 2);
        push_msg(1, 1, 3);
        drain(50);
        chki("t2_beats", beat_cnt, 3);
        chki("t2_msg_done", done_cnt, 2);
        chk1("t2_err_len", err_len, 1'b0);

        // Oversized header clamps to 16; following word is a fresh header
        clear_counts();
        push_msg(40, 16, 4);
        push_msg(2, 2, 5);
        drain(100);
        chk1("t3_err_len", err_len, 1'b1);
        chk1("t3_err_model", err_len, exp_err);
        chki("t3_beats", beat_cnt, 20);
        chki("t3_msg_done", done_cnt, 2);

        // Backpressure: ready low for 10 cycles over a 5-word message
        bus.m_tready = 1'b0;
        clear_counts();
        push_msg(4, 4, 6);
        repeat (10) tick();
        chki("t4_pops_stalled", rden_cnt, 2);
        chk1("t4_rden_off", bus.fifo_rden, 1'b0);
        chk1("t4_valid", bus.m_tvalid, 1'b1);
        chkw("t4_head_data", bus.m_tdata, last_hdr);
        bus.m_tready = 1'b1;
        drain(50);
        chki("t4_beats", beat_cnt, 5);
        chki("t4_msg_done", done_cnt, 1);

        // Flush mid-message with a full buffer
        chk1("t5_err_before", err_len, 1'b1);
        bus.m_tready = 1'b0;
        clear_counts();
        push_msg(4, 2, 7);
        repeat (4) tick();
        flush = 1'b1;
        fq.delete();
        exp_q.delete();
        exp_err = 1'b0;
        drive_fifo();
        tick();
        flush = 1'b0;
        chk1("t5_tvalid_after_flush", bus.m_tvalid, 1'b0);
        chk1("t5_err_len_cleared", err_len, 1'b0);
        bus.m_tready = 1'b1;
        push_msg(1, 1, 8);
        wait_valid(20);
        chk1("t5_first_tuser", bus.m_tuser, 1'b1);
        drain(50);
        chki("t5_msg_done", done_cnt, 1);

        // Asynchronous reset mid-payload
        clear_counts();
        push_msg(6, 6, 9);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        chk1("t6_tvalid_async", bus.m_tvalid, 1'b0);
        chk1("t6_rden_async", bus.fifo_rden, 1'b0);
        chk1("t6_msg_done_async", msg_done, 1'b0);
        fq.delete();
        exp_q.delete();
        exp_err = 1'b0;
        drive_fifo();
        tick();
        tick();
        reset = 1'b0;
        clear_counts();
        push_msg(0, 0, 10);
        push_msg(2, 2, 11);
        wait_valid(20);
        chk1("t6_hdr_tuser", bus.m_tuser, 1'b1);
        chk1("t6_hdr_tlast", bus.m_tlast, 1'b1);
        drain(50);
        chki("t6_beats", beat_cnt, 4);
        chki("t6_msg_done", done_cnt, 2);

`ifdef QDMA_MBOX_RD_PARITY_EN
        // Header word 0x01 -> byte 0 parity 1
        bus.m_tready = 1'b0;
        push_msg(1, 1, 0);
        repeat (2) tick();
        chk1("par_byte0", bus.m_tparity[0], 1'b1);
        chk1("par_byte1", bus.m_tparity[1], 1'b0);
        bus.m_tready = 1'b1;
        drain(50);
        chk1("err_par_clear", err_par, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qdma_mailbox_fifo_rd_adapter.md
Name: qdma_mailbox_fifo_rd_adapter

Overview:
- Read-side stage directly downstream of the mailbox generic FIFO.
- Pops words from the FIFO's show-ahead port (combinational DataOut, registered empty). Parses length-prefixed mailbox messages. Presents them as an AXI4-Stream master with tlast framing.
- A 2-entry output buffer decouples FIFO pops from downstream backpressure while sustaining 1 beat/cycle.

Parameters:
- DATA_W, 256: FIFO word and stream data width.
- LEN_W, 8: width of the header length field, header bits [LEN_W-1:0].
- MAX_LEN, 16: maximum payload words per message (excludes header).

Ports:
- clkin  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous flush, active-high; drops the in-flight message and buffer contents.
- fifo_dout  in  DATA_W  FIFO read data, valid combinationally at the current read pointer.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rden  out  1  FIFO pop strobe.
- m_tdata  out  DATA_W  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  last beat of a message.
- m_tuser  out  1  first beat of a message (the header).
- msg_done  out  1  one-cycle pulse when a tlast beat handshakes.
- err_len  out  1  sticky length error; cleared by reset or flush.

Behaviour:
- Reset values:
  - fifo_rden=0, m_tvalid=0, m_tlast=0, m_tuser=0, msg_done=0, err_len=0, m_tdata=0.
  - State HDR, buffer empty, remaining count 0.
- Pop rule:
  - fifo_rden = ~fifo_empty & ~flush & (buffer occupancy < 2, after counting the same-cycle m_tvalid&m_tready drain).
  - fifo_dout is captured in the same cycle fifo_rden is high.
- Latency: a popped word appears on m_tdata one cycle later when the buffer was empty. Throughput is 1 beat/cycle under continuous m_tready.
- Buffer:
  - 2-entry FIFO ordered head/tail; the head drives the m_* outputs.
  - Simultaneous push and pop at occupancy 1 or 2 keeps occupancy and ordering.
  - m_* outputs are stable while m_tvalid & ~m_tready (AXI rule).
- State machine (advances on each pop, not on each handshake):
  - HDR: the popped word is a header. Take N = word[LEN_W-1:0].
    - If N > MAX_LEN, set err_len and use N = MAX_LEN.
    - Tag the beat tuser=1.
    - If N == 0, tag tlast=1 and stay in HDR.
    - Otherwise load rem=N and go to PAY.
  - PAY: the popped word is payload, tuser=0, rem decrements.
    - When rem==1 the beat is tagged tlast=1 and the state returns to HDR.
- rem is LEN_W bits wide; the clamp guarantees no underflow or wrap.
- fifo_empty deasserts one cycle late after a FIFO write. The adapter never pops while empty=1, even if data is physically present.
- flush, in the cycle it is high:
  - fifo_rden=0, buffer cleared (m_tvalid=0 next cycle), state set to HDR, err_len cleared.
  - A handshake that is concurrent with flush still counts at the sink, but msg_done is suppressed.
- Reset mid-message: everything returns to reset values asynchronously. The next popped word is treated as a header.
- msg_done asserts the cycle after m_tvalid&m_tready&m_tlast.

Optional Feature:
- Macro QDMA_MBOX_RD_PARITY_EN.
- When defined:
  - Adds output m_tparity [DATA_W/8], even parity per byte of m_tdata, computed at capture and stored in the buffer beside the data.
  - Adds sticky output err_par, set if fifo_dout has all bytes 8'hFF in PAY state (poison marker). Cleared by reset or flush.
- When undefined: neither port exists and no parity storage is built.

Decomposition:
- Shared package qdma_mbox_pkg:
  - typedef mbox_state_e {HDR, PAY}.
  - Constants MBOX_LEN_LSB=0 and MBOX_DEF_MAX_LEN=16.
  - struct mbox_beat_t {data, last, user[, parity]}.
- One sub-module, qdma_mbox_skid2: a generic 2-entry valid/ready buffer of mbox_beat_t with occupancy output.

Test Plan:
- Header N=3 followed by 3 payload words, m_tready=1:
  - 4 consecutive beats with tuser=1 on beat 0 and tlast=1 on beat 3.
  - msg_done pulses once; fifo_rden high for 4 cycles.
- Header N=0 then header N=1 plus 1 payload:
  - Beat 0 carries tuser=1 and tlast=1.
  - Then a 2-beat message; 2 msg_done pulses total.
- Header N=40 with MAX_LEN=16:
  - err_len=1; message ends after 16 payload beats with tlast.
  - The next FIFO word is treated as a header.
- m_tready held low for 10 cycles during a 5-word message:
  - At most 2 pops occur, then fifo_rden=0 and m_tdata is stable.
  - After release, all beats arrive in order with no loss or duplication.
- flush asserted after 2 of 4 payload beats:
  - m_tvalid=0 the next cycle; err_len cleared.
  - The next popped word is tagged tuser=1.
- reset asserted asynchronously mid-PAY:
  - m_tvalid=0 immediately; after deassertion the first pop is parsed as a header.
  - With QDMA_MBOX_RD_PARITY_EN defined, data 0x01 in byte 0 gives m_tparity[0]=1.
